// File: rtl/apb4_arb_pkg.sv
// Shared constants for the APB4 round-robin master: FSM encodings, bus widths
// and the timeout counter sizing helper.
package apb4_arb_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    // Wide enough to hold the value TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb4_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping, as both a one-hot grant and a binary index.
module apb4_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(NREQ)) begin
                sum = sum - (IW + 1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!any && valid[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb4_master_arb.sv
// Round-robin arbiter plus APB4 master sequencer sharing one register slave.
// Define APB4_MASTER_ARB_TIMEOUT_EN to abort ACCESS phases stuck for TIMEOUT cycles.
module apb4_master_arb
    import apb4_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0]    req_wdata,
    input  logic [NREQ*STRB_W-1:0]    req_strb,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDRWIDTH-1:0]      paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [STRB_W-1:0]         pstrb,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb4_master_arb: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    logic [1:0]           state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        next_ptr;
    logic [IW-1:0]        pick_ptr;
    logic [IW-1:0]        pick_idx;
    logic [NREQ-1:0]      pick_onehot;
    logic                 pick_any;
    logic                 done;
    logic                 launch;
    logic                 timeout_hit;
    logic                 sel_write;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [STRB_W-1:0]    sel_strb;

    // On completion the pointer moves past the finishing requester, and a
    // back-to-back pick must already see that advanced pointer.
    assign next_ptr = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    assign pick_ptr = (state == ACCESS) ? next_ptr : rr_ptr;
    assign done     = (state == ACCESS) && pready && !timeout_hit;
    assign launch   = pick_any && ((state == IDLE) || done);

    apb4_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .grant (pick_onehot),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDRWIDTH +: ADDRWIDTH];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_strb  = req_strb[i*STRB_W +: STRB_W];
            end
        end
    end

`ifdef APB4_MASTER_ARB_TIMEOUT_EN
    localparam int TW = tmo_width(TIMEOUT);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge pclk) begin
        if (preset || state != ACCESS) begin
            tmo_cnt <= '0;
        end else if (!pready) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Fires on the TIMEOUT-th stalled ACCESS cycle.
    assign timeout_hit = (state == ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (timeout_hit) begin
                        rsp_valid[grant_idx] <= 1'b1;
                        rsp_rdata            <= '0;
                        rsp_err              <= 1'b1;
                        rr_ptr               <= next_ptr;
                        psel                 <= 1'b0;
                        penable              <= 1'b0;
                        state                <= IDLE;
                    end else if (pready) begin
                        rsp_valid[grant_idx] <= 1'b1;
                        rsp_rdata            <= pwrite ? '0 : prdata;
                        rsp_err              <= pslverr;
                        rr_ptr               <= next_ptr;
                        if (!launch) begin
                            psel    <= 1'b0;
                            penable <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase

            // Shared by the IDLE start and the back-to-back restart.
            if (launch) begin
                state     <= SETUP;
                psel      <= 1'b1;
                penable   <= 1'b0;
                grant_idx <= pick_idx;
                req_ready <= pick_onehot;
                pwrite    <= sel_write;
                paddr     <= sel_addr;
                if (sel_write) begin
                    pwdata <= sel_wdata;
                    pstrb  <= sel_strb;
                end else begin
                    pstrb  <= '0;
                end
            end
        end
    end

endmodule
